// File: rtl/dual_bin_to_bcd_pkg.sv
// Shared constants and FSM encoding for the dual binary-to-BCD converter.
package dual_bin_to_bcd_pkg;

  localparam int BIN_W_DEFAULT   = 14;
  localparam int N_DIG_DEFAULT   = 4;
  localparam int MAX_VAL_DEFAULT = 9999;
  localparam int NIB_W           = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV_A = 2'd1,
    CONV_B = 2'd2
  } state_e;

endpackage

// File: rtl/dual_bin_to_bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every nibble >= 5, then shift in the next binary bit.
module dual_bin_to_bcd_dabble_step
  import dual_bin_to_bcd_pkg::*;
#(
  parameter int N_DIG = N_DIG_DEFAULT
) (
  input  logic [NIB_W*N_DIG-1:0] bcd_i,
  input  logic                   bin_msb_i,
  output logic [NIB_W*N_DIG-1:0] bcd_o
);

  logic [NIB_W*N_DIG-1:0] adj;

  always_comb begin
    adj = bcd_i;
    for (int i = 0; i < N_DIG; i++) begin
      if (bcd_i[i*NIB_W +: NIB_W] >= 4'd5) begin
        adj[i*NIB_W +: NIB_W] = bcd_i[i*NIB_W +: NIB_W] + 4'd3;
      end
    end
  end

  assign bcd_o = {adj[NIB_W*N_DIG-2:0], bin_msb_i};

endmodule

// File: rtl/dual_bin_to_bcd.sv
// Converts two saturated binary counts to packed BCD with one shared double-dabble engine,
// A first then B, publishing both results together on a single done edge.
module dual_bin_to_bcd
  import dual_bin_to_bcd_pkg::*;
#(
  parameter int BIN_W   = BIN_W_DEFAULT,
  parameter int N_DIG   = N_DIG_DEFAULT,
  parameter int MAX_VAL = MAX_VAL_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [BIN_W-1:0]       value_A,
  input  logic [BIN_W-1:0]       value_B,
  output logic [NIB_W*N_DIG-1:0] digits_A,
  output logic [NIB_W*N_DIG-1:0] digits_B,
  output logic                   busy,
  output logic                   done,
  output logic                   ovf_A,
  output logic                   ovf_B
);

  localparam int                BCD_W    = NIB_W * N_DIG;
  localparam int                CNT_W    = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(BIN_W - 1);
  localparam logic [BIN_W-1:0]  MAX_BIN  = BIN_W'(MAX_VAL);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [BIN_W-1:0]   bin_b_q, bin_b_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BCD_W-1:0]   hold_a_q, hold_a_d;
  logic               stage_ovf_a_q, stage_ovf_a_d;
  logic               stage_ovf_b_q, stage_ovf_b_d;
  logic [BCD_W-1:0]   digits_a_q, digits_a_d;
  logic [BCD_W-1:0]   digits_b_q, digits_b_d;
  logic               ovf_a_q, ovf_a_d;
  logic               ovf_b_q, ovf_b_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [BCD_W-1:0]   bcd_step;
  logic               last_iter;
  logic               sat_a, sat_b;

  dual_bin_to_bcd_dabble_step #(.N_DIG(N_DIG)) u_step (
    .bcd_i     (bcd_q),
    .bin_msb_i (bin_q[BIN_W-1]),
    .bcd_o     (bcd_step)
  );

  assign last_iter = (cnt_q == LAST_CNT);
  assign sat_a     = (value_A > MAX_BIN);
  assign sat_b     = (value_B > MAX_BIN);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (load)      state_d = CONV_A;
      CONV_A:  if (last_iter) state_d = CONV_B;
      CONV_B:  if (last_iter) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Datapath: capture in IDLE, iterate per state, commit both results on B's last step.
  always_comb begin
    cnt_d         = cnt_q;
    bin_d         = bin_q;
    bin_b_d       = bin_b_q;
    bcd_d         = bcd_q;
    hold_a_d      = hold_a_q;
    stage_ovf_a_d = stage_ovf_a_q;
    stage_ovf_b_d = stage_ovf_b_q;
    digits_a_d    = digits_a_q;
    digits_b_d    = digits_b_q;
    ovf_a_d       = ovf_a_q;
    ovf_b_d       = ovf_b_q;
    done_d        = 1'b0;
    busy_d        = (state_d != IDLE);
    unique case (state_q)
      IDLE: begin
        if (load) begin
          cnt_d         = '0;
          bcd_d         = '0;
          bin_d         = sat_a ? MAX_BIN : value_A;
          bin_b_d       = sat_b ? MAX_BIN : value_B;
          stage_ovf_a_d = sat_a;
          stage_ovf_b_d = sat_b;
        end
      end
      CONV_A: begin
        bcd_d = bcd_step;
        bin_d = bin_q << 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_iter) begin
          hold_a_d = bcd_step;
          bcd_d    = '0;
          bin_d    = bin_b_q;
          cnt_d    = '0;
        end
      end
      CONV_B: begin
        bcd_d = bcd_step;
        bin_d = bin_q << 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_iter) begin
          cnt_d      = '0;
          digits_a_d = hold_a_q;
          digits_b_d = bcd_step;
          ovf_a_d    = stage_ovf_a_q;
          ovf_b_d    = stage_ovf_b_q;
          done_d     = 1'b1;
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      bin_q         <= '0;
      bin_b_q       <= '0;
      bcd_q         <= '0;
      hold_a_q      <= '0;
      stage_ovf_a_q <= 1'b0;
      stage_ovf_b_q <= 1'b0;
      digits_a_q    <= '0;
      digits_b_q    <= '0;
      ovf_a_q       <= 1'b0;
      ovf_b_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      bin_q         <= bin_d;
      bin_b_q       <= bin_b_d;
      bcd_q         <= bcd_d;
      hold_a_q      <= hold_a_d;
      stage_ovf_a_q <= stage_ovf_a_d;
      stage_ovf_b_q <= stage_ovf_b_d;
      digits_a_q    <= digits_a_d;
      digits_b_q    <= digits_b_d;
      ovf_a_q       <= ovf_a_d;
      ovf_b_q       <= ovf_b_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign digits_A = digits_a_q;
  assign digits_B = digits_b_q;
  assign ovf_A    = ovf_a_q;
  assign ovf_B    = ovf_b_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_dual_bin_to_bcd.sv
// Directed bench for dual_bin_to_bcd: expected results are queued when a load is accepted
// and popped when done pulses.
module tb_dual_bin_to_bcd;

  localparam int BIN_W   = 14;
  localparam int N_DIG   = 4;
  localparam int MAX_VAL = 9999;
  localparam int LAT     = 29;
  localparam int BUSY_N  = 28;

  typedef struct packed {
    logic [15:0] da;
    logic [15:0] db;
    logic        oa;
    logic        ob;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             load;
  logic [BIN_W-1:0] value_A;
  logic [BIN_W-1:0] value_B;
  logic [15:0]      digits_A;
  logic [15:0]      digits_B;
  logic             busy;
  logic             done;
  logic             ovf_A;
  logic             ovf_B;

  exp_t exp_q[$];
  exp_t last_exp = '0;
  int   tests_run = 0;
  int   tests_failed = 0;

  dual_bin_to_bcd #(.BIN_W(BIN_W), .N_DIG(N_DIG), .MAX_VAL(MAX_VAL)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .value_A  (value_A),
    .value_B  (value_B),
    .digits_A (digits_A),
    .digits_B (digits_B),
    .busy     (busy),
    .done     (done),
    .ovf_A    (ovf_A),
    .ovf_B    (ovf_B)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int          t;
    r = '0;
    t = v;
    for (int i = 0; i < N_DIG; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic exp_t model(input int a, input int b);
    exp_t e;
    e.oa = (a > MAX_VAL);
    e.ob = (b > MAX_VAL);
    e.da = to_bcd(e.oa ? MAX_VAL : a);
    e.db = to_bcd(e.ob ? MAX_VAL : b);
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives load from the current (negedge) time through the next posedge, then scrambles inputs.
  task automatic applyStimulus(input int a, input int b, input bit accept);
    value_A = BIN_W'(a);
    value_B = BIN_W'(b);
    load    = 1'b1;
    if (accept) exp_q.push_back(model(a, b));
    @(posedge clk);
    #1;
    load    = 1'b0;
    value_A = BIN_W'($urandom);
    value_B = BIN_W'($urandom);
  endtask

  task automatic waitDone(input int budget, input int load_at, output int lat,
                          output int busy_cnt, output int first_busy, output int hold_err);
    lat = 0; busy_cnt = 0; first_busy = 0; hold_err = 0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (busy) begin
        busy_cnt++;
        if (first_busy == 0) first_busy = c;
      end
      if (done) begin
        lat = c;
        break;
      end
      if ({digits_A, digits_B, ovf_A, ovf_B} !== {last_exp.da, last_exp.db, last_exp.oa, last_exp.ob})
        hold_err++;
      if (c == load_at) begin
        value_A = 14'd3333;
        value_B = 14'd4444;
        load    = 1'b1;
      end else if (c == load_at + 1) begin
        load = 1'b0;
      end
    end
    load = 1'b0;
  endtask

  task automatic runCheck(input string tag, input int load_at);
    int   lat, bc, fb, he;
    exp_t e;
    waitDone(60, load_at, lat, bc, fb, he);
    checkOutput({tag, ".done_seen"}, 32'(lat != 0), 32'd1);
    checkOutput({tag, ".latency"}, lat, LAT);
    checkOutput({tag, ".busy_cycles"}, bc, BUSY_N);
    checkOutput({tag, ".busy_start"}, fb, 1);
    checkOutput({tag, ".hold_before_done"}, he, 0);
    checkOutput({tag, ".busy_at_done"}, 32'(busy), 32'd0);
    if (exp_q.size() == 0) begin
      checkOutput({tag, ".scoreboard_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      checkOutput({tag, ".digits_A"}, 32'(digits_A), 32'(e.da));
      checkOutput({tag, ".digits_B"}, 32'(digits_B), 32'(e.db));
      checkOutput({tag, ".ovf_A"}, 32'(ovf_A), 32'(e.oa));
      checkOutput({tag, ".ovf_B"}, 32'(ovf_B), 32'(e.ob));
      last_exp = e;
    end
  endtask

  initial begin
    int done_cnt;
    rst = 1'b1; load = 1'b0; value_A = '0; value_B = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset.digits_A", 32'(digits_A), 32'd0);
    checkOutput("reset.digits_B", 32'(digits_B), 32'd0);
    checkOutput("reset.busy", 32'(busy), 32'd0);
    checkOutput("reset.done", 32'(done), 32'd0);
    checkOutput("reset.ovf", 32'({ovf_A, ovf_B}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(1234, 5678, 1'b1);
    runCheck("basic", 0);
    @(negedge clk);
    checkOutput("basic.done_single", 32'(done), 32'd0);

    applyStimulus(0, 9999, 1'b1);
    runCheck("zero_max", 0);
    @(negedge clk);
    applyStimulus(9, 10, 1'b1);
    runCheck("small", 0);
    @(negedge clk);

    applyStimulus(12000, 16383, 1'b1);
    runCheck("saturate", 0);
    @(negedge clk);
    applyStimulus(42, 16383, 1'b1);
    runCheck("ovf_clear", 0);
    @(negedge clk);

    applyStimulus(1111, 2222, 1'b1);
    runCheck("ignored_load", 10);
    done_cnt = 0;
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    checkOutput("ignored_load.extra_done", done_cnt, 0);

    applyStimulus(1234, 4321, 1'b1);
    void'(exp_q.pop_back());
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort.outputs", 32'({digits_A, digits_B}), 32'd0);
    checkOutput("abort.flags", 32'({busy, done, ovf_A, ovf_B}), 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) done_cnt++;
    end
    checkOutput("abort.no_done", done_cnt, 0);
    last_exp = '0;

    applyStimulus(100, 200, 1'b1);
    runCheck("b2b_first", 0);
    applyStimulus(300, 400, 1'b1);
    runCheck("b2b_second", 0);
    checkOutput("scoreboard.drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dual_bin_to_bcd.md
Name: dual_bin_to_bcd

Overview:
- Sequential binary-to-BCD converter feeding the dual 8-digit display controller.
- Takes two binary counts from the lifetime measurement logic (A = right number, B = left number).
- Converts both with one shared shift-and-add-3 (double-dabble) engine: A first, then B.
- Presents both 4-digit packed-BCD results together, so the display never shows a mixed old/new pair.

Parameters:
- BIN_W, 14: width of each binary input. Must be ≥14 so 9999 is representable.
- N_DIG, 4: BCD digits per output.
- MAX_VAL, 9999: saturation limit, equal to 10^N_DIG − 1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- load  in  1  start pulse; samples value_A and value_B
- value_A  in  BIN_W  binary count for the right number
- value_B  in  BIN_W  binary count for the left number
- digits_A  out  4*N_DIG  packed BCD of value_A; [3:0] = ones, [15:12] = thousands
- digits_B  out  4*N_DIG  packed BCD of value_B; same layout
- busy  out  1  conversion in progress
- done  out  1  one-cycle pulse when digits_A/digits_B update
- ovf_A  out  1  value_A exceeded MAX_VAL on the last accepted load
- ovf_B  out  1  value_B exceeded MAX_VAL on the last accepted load

Behaviour:
- Reset is synchronous, active-high, and has priority over everything. Reset values:
  - digits_A = digits_B = 0
  - busy = 0, done = 0, ovf_A = ovf_B = 0
  - FSM in IDLE, shift counter = 0, scratch registers = 0
- FSM states: IDLE, CONV_A, CONV_B.
  - IDLE: load = 1 at edge T captures both inputs and goes to CONV_A with counter = 0.
  - Capture saturates each input: a value > MAX_VAL is replaced by MAX_VAL and sets the matching ovf flag in a staging register.
  - CONV_A: one double-dabble iteration per clock, BIN_W clocks total.
    - Each iteration: every BCD nibble ≥ 5 gets +3, then {bcd, bin} shifts left by 1.
  - On the last CONV_A iteration (counter = BIN_W−1), the result goes to internal hold_A, the counter clears, and the FSM moves to CONV_B.
  - CONV_B: same as CONV_A, for B.
  - On the last CONV_B iteration, all of the following load together in one edge, then the FSM returns to IDLE:
    - digits_A ← hold_A
    - digits_B ← result B
    - ovf_A/ovf_B ← staged flags
    - done ← 1
- Timing:
  - busy is a registered output, high from edge T+1 through the cycle after edge T+2*BIN_W; it is high for exactly 2*BIN_W cycles (28 at the default).
  - done is high for exactly one cycle, the first cycle after busy falls.
  - Outputs change only on the done edge and hold otherwise.
- Boundary conditions:
  - load while busy: ignored, with no effect on the conversion in progress.
  - load in the cycle done is high: the FSM is already IDLE, so it is accepted. The next busy period starts immediately and the current outputs hold until the next done.
  - Input of 0: produces 0x0000. Input equal to MAX_VAL: produces 0x9999 with ovf = 0.
  - value_A/value_B may change after the load edge with no effect; they are sampled only at capture.
  - rst during a conversion aborts it. All outputs return to reset values and no done pulse follows.
  - The counter needs only a width of ceil(log2(BIN_W)) and must never exceed BIN_W−1.
- Arithmetic width: the BCD scratch is 4*N_DIG bits. Saturation guarantees no carry out of the top nibble.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE, CONV_A, CONV_B)
  - BIN_W, N_DIG, MAX_VAL defaults
  - BCD nibble width constant (4)
- One natural sub-module: dabble_step.
  - Purely combinational.
  - Inputs: BCD scratch (4*N_DIG) and incoming bin MSB.
  - Performs the add-3 on each nibble ≥ 5, then the 1-bit left shift; returns the next BCD scratch.
  - Instantiated once and shared between CONV_A and CONV_B.

Test Plan:
- Reset, then load with value_A = 1234 and value_B = 5678:
  - busy high for exactly 28 cycles; done is a single pulse at load edge + 29 cycles.
  - digits_A = 0x1234, digits_B = 0x5678, ovf_A = ovf_B = 0.
- value_A = 0, value_B = 9999 → digits_A = 0x0000, digits_B = 0x9999, no overflow. Then value_A = 9, value_B = 10 → 0x0009, 0x0010.
- value_A = 12000, value_B = 16383 → digits_A = digits_B = 0x9999, ovf_A = ovf_B = 1. A following load with value_A = 42 clears ovf_A on its done.
- Start A = 1111/B = 2222, then pulse load with 3333/4444 at busy cycle 10:
  - second load ignored; result 0x1111/0x2222 after 28 cycles.
  - exactly one done; outputs unchanged before that done.
- Start a conversion, assert rst at busy cycle 15 → next cycle all outputs 0, busy = 0, and no done for at least 40 cycles.
- Back-to-back: load 100/200, then load 300/400 in the done cycle:
  - first done gives 0x0100/0x0200 and busy rises again the next cycle.
  - second done arrives exactly 29 cycles after the first, giving 0x0300/0x0400.
